// File: rtl/weight_preload_dma.sv
// rtl/weight_preload_dma.sv - Burst sequencer that preloads weight words from external memory into the weight buffer.
module weight_preload_dma #(
    parameter int                    ADDR_W     = 16,
    parameter int                    BUF_ADDR_W = 16,
    parameter int                    DATA_W     = 128,
    parameter int                    EXT_ADDR_W = 32,
    parameter logic [EXT_ADDR_W-1:0] EXT_BASE   = '0,
    parameter int                    MAX_BURST  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  preload_req,
    input  logic [ADDR_W-1:0]     preload_base,
    input  logic [16:0]           preload_count,
    output logic                  preload_done,
    output logic                  rd_req_valid,
    input  logic                  rd_req_ready,
    output logic [EXT_ADDR_W-1:0] rd_req_addr,
    output logic [7:0]            rd_req_len,
    input  logic                  rd_data_valid,
    output logic                  rd_data_ready,
    input  logic [DATA_W-1:0]     rd_data,
    input  logic                  rd_data_last,
    output logic                  buf_we,
    output logic [BUF_ADDR_W-1:0] buf_waddr,
    output logic [DATA_W-1:0]     buf_wdata,
    output logic                  busy,
    output logic                  err
);
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_DATA, S_FLUSH, S_DONE, S_WREL} state_t;

    localparam logic [EXT_ADDR_W-1:0] BYTES = EXT_ADDR_W'(DATA_W / 8);

    state_t            state, state_nx;
    logic [ADDR_W-1:0] base_q;
    logic [16:0]       count_q;
    logic [16:0]       issued_q;
    logic [16:0]       written_q;
    logic [8:0]        beats_left_q;
    logic [16:0]       remaining;
    logic [16:0]       burst;
    logic              beat_ok;
    logic              final_beat;

    // issued_q advances at the request handshake, so remaining already excludes the burst in flight
    assign remaining  = count_q - issued_q;
    assign burst      = (remaining > 17'(MAX_BURST)) ? 17'(MAX_BURST) : remaining;
    assign beat_ok    = (state == S_DATA) && rd_data_valid;
    assign final_beat = (beats_left_q == 9'd1);
    assign busy       = (state != S_IDLE);

    assign rd_req_addr = (state == S_REQ)
                       ? EXT_BASE + (EXT_ADDR_W'(base_q) + EXT_ADDR_W'(issued_q)) * BYTES
                       : '0;
    assign rd_req_len  = (state == S_REQ) ? 8'(burst - 17'd1) : 8'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        rd_req_valid  = 1'b0;
        rd_data_ready = 1'b0;
        preload_done  = 1'b0;
        case (state)
            S_IDLE: begin
                if (preload_req) begin
                    state_nx = (preload_count == 17'd0) ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                rd_req_valid = 1'b1;
                if (rd_req_ready) begin
                    state_nx = S_DATA;
                end
            end
            S_DATA: begin
                rd_data_ready = 1'b1;
                if (rd_data_valid && final_beat) begin
                    state_nx = (remaining == 17'd0) ? S_FLUSH : S_REQ;
                end
            end
            S_FLUSH: state_nx = S_DONE;
            S_DONE: begin
                preload_done = 1'b1;
                state_nx     = S_WREL;
            end
            S_WREL: begin
                if (!preload_req) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q       <= '0;
            count_q      <= '0;
            issued_q     <= '0;
            written_q    <= '0;
            beats_left_q <= '0;
            buf_we       <= 1'b0;
            buf_waddr    <= '0;
            buf_wdata    <= '0;
            err          <= 1'b0;
        end else begin
            buf_we <= beat_ok;
            if (state == S_IDLE && preload_req) begin
                base_q    <= preload_base;
                count_q   <= preload_count;
                issued_q  <= '0;
                written_q <= '0;
                err       <= 1'b0;
            end
            if (state == S_REQ && rd_req_ready) begin
                issued_q     <= issued_q + burst;
                beats_left_q <= 9'(burst);
            end
            // Burst length is tracked by our own counter; rd_data_last is only cross-checked
            if (beat_ok) begin
                buf_wdata    <= rd_data;
                buf_waddr    <= BUF_ADDR_W'(EXT_ADDR_W'(base_q) + EXT_ADDR_W'(written_q));
                written_q    <= written_q + 17'd1;
                beats_left_q <= beats_left_q - 9'd1;
                if (rd_data_last != final_beat) begin
                    err <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_weight_preload_dma.sv
// tb/tb_weight_preload_dma.sv - Self-checking bench for weight_preload_dma against a burst/write reference model.
module tb_weight_preload_dma;
    localparam int MAXB = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         preload_req;
    logic [15:0]  preload_base;
    logic [16:0]  preload_count;
    logic         preload_done;
    logic         rd_req_valid;
    logic         rd_req_ready;
    logic [31:0]  rd_req_addr;
    logic [7:0]   rd_req_len;
    logic         rd_data_valid;
    logic         rd_data_ready;
    logic [127:0] rd_data;
    logic         rd_data_last;
    logic         buf_we;
    logic [15:0]  buf_waddr;
    logic [127:0] buf_wdata;
    logic         busy;
    logic         err;

    weight_preload_dma dut (
        .clk(clk), .rst_n(rst_n),
        .preload_req(preload_req), .preload_base(preload_base),
        .preload_count(preload_count), .preload_done(preload_done),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
        .rd_req_addr(rd_req_addr), .rd_req_len(rd_req_len),
        .rd_data_valid(rd_data_valid), .rd_data_ready(rd_data_ready),
        .rd_data(rd_data), .rd_data_last(rd_data_last),
        .buf_we(buf_we), .buf_waddr(buf_waddr), .buf_wdata(buf_wdata),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] base;
        logic [16:0] count;
        int          stall;
        int          gap;
        int          bad;
        logic        exp_err;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [15:0]  wq_addr[$];
    logic [127:0] wq_data[$];
    logic [31:0]  rq_addr[$];
    logic [7:0]   rq_len[$];
    logic [127:0] bq_data[$];
    logic         bq_last[$];

    int done_cnt, done_cyc, last_acc_cyc, valid_cyc, cur_count;
    int gbeat, bad_beat, stall_cfg, gap_pct;
    logic chk_done_writes = 1'b1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] mem_word(input logic [31:0] idx);
        return {idx * 32'h9E3779B9, ~idx, idx ^ 32'h5A5A5A5A, idx + 32'h1234};
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Observer: buffer writes, accepted burst requests and done pulses
    initial forever begin
        @(negedge clk);
        if (buf_we) begin
            wq_addr.push_back(buf_waddr);
            wq_data.push_back(buf_wdata);
        end
        if (rd_req_valid && rd_req_ready) begin
            rq_addr.push_back(rd_req_addr);
            rq_len.push_back(rd_req_len);
        end
        if (rd_req_valid) valid_cyc++;
        if (preload_done) begin
            done_cnt++;
            done_cyc = cyc;
            if (chk_done_writes) chk("writes_before_done", 128'(wq_addr.size()), 128'(cur_count));
        end
    end

    // External memory model: answers each accepted burst with len+1 beats from mem_word()
    initial begin
        logic        hs, acc, prev_v, prev_r;
        logic [31:0] hs_addr, prev_addr;
        logic [7:0]  hs_len, prev_len;
        int          wait_cnt;
        hs = 0; acc = 0; prev_v = 0; prev_r = 0; wait_cnt = 0;
        hs_addr = 0; hs_len = 0; prev_addr = 0; prev_len = 0;
        rd_req_ready = 0; rd_data_valid = 0; rd_data = '0; rd_data_last = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                bq_data.delete(); bq_last.delete();
                hs = 0; acc = 0; prev_v = 0; prev_r = 0; wait_cnt = 0;
                rd_req_ready = 0; rd_data_valid = 0;
            end else begin
                if (hs) begin
                    for (int k = 0; k <= int'(hs_len); k++) begin
                        bq_data.push_back(mem_word((hs_addr >> 4) + 32'(k)));
                        bq_last.push_back((k == int'(hs_len)) ^ (gbeat == bad_beat));
                        gbeat++;
                    end
                end
                if (acc && bq_data.size() > 0) begin
                    void'(bq_data.pop_front());
                    void'(bq_last.pop_front());
                    last_acc_cyc = cyc;
                end
                if (prev_v && !prev_r && rd_req_valid) begin
                    chk("req_addr_stable", 128'(rd_req_addr), 128'(prev_addr));
                    chk("req_len_stable", 128'(rd_req_len), 128'(prev_len));
                end
                if (rd_req_valid) begin
                    rd_req_ready = (wait_cnt >= stall_cfg);
                    wait_cnt++;
                end else begin
                    rd_req_ready = 1'($urandom_range(0, 1));
                    wait_cnt = 0;
                end
                hs = rd_req_valid && rd_req_ready;
                if (hs) wait_cnt = 0;
                hs_addr = rd_req_addr; hs_len = rd_req_len;
                prev_v = rd_req_valid; prev_r = rd_req_ready;
                prev_addr = rd_req_addr; prev_len = rd_req_len;
                if (bq_data.size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
                    rd_data_valid = 1'b1;
                    rd_data       = bq_data[0];
                    rd_data_last  = bq_last[0];
                end else begin
                    rd_data_valid = (bq_data.size() == 0) && ($urandom_range(0, 3) == 0);
                    rd_data       = {$urandom, $urandom, $urandom, $urandom};
                    rd_data_last  = 1'($urandom_range(0, 1));
                end
                acc = rd_data_valid && rd_data_ready;
            end
        end
    end

    task automatic run_xfer(input vec_t v);
        int n, req_cyc, w, j, b;
        wq_addr.delete(); wq_data.delete(); rq_addr.delete(); rq_len.delete();
        done_cnt = 0; last_acc_cyc = -1; valid_cyc = 0; gbeat = 0;
        bad_beat = v.bad; stall_cfg = v.stall; gap_pct = v.gap; cur_count = int'(v.count);
        preload_base = v.base; preload_count = v.count; preload_req = 1'b1;
        @(posedge clk); #1;
        req_cyc = cyc;
        preload_base = 16'($urandom);
        preload_count = 17'($urandom);
        n = 0;
        while (done_cnt == 0 && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("done_seen", 128'(done_cnt != 0), 128'(1));
        if (v.count == 0) begin
            chk("zero_done_latency", 128'(done_cyc - req_cyc), 128'(0));
            chk("zero_no_req_valid", 128'(valid_cyc), 128'(0));
        end else begin
            chk("done_latency", 128'(done_cyc), 128'(last_acc_cyc + 1));
        end
        repeat (4) begin @(posedge clk); #1; end
        chk("held_req_no_retrigger", 128'(done_cnt), 128'(1));
        chk("busy_in_wrel", 128'(busy), 128'(1));
        preload_req = 1'b0;
        @(posedge clk); #1;
        chk("idle_after_release", 128'(busy), 128'(0));
        chk("err_flag", 128'(err), 128'(v.exp_err));
        chk("write_count", 128'(wq_addr.size()), 128'(v.count));
        for (int i = 0; i < int'(v.count) && i < wq_addr.size(); i++) begin
            chk("waddr", 128'(wq_addr[i]), 128'(16'(32'(v.base) + 32'(i))));
            chk("wdata", wq_data[i], mem_word(32'(v.base) + 32'(i)));
        end
        w = 0; j = 0;
        while (w < int'(v.count)) begin
            b = (int'(v.count) - w > MAXB) ? MAXB : int'(v.count) - w;
            if (j < rq_addr.size()) begin
                chk("burst_addr", 128'(rq_addr[j]), 128'((32'(v.base) + 32'(w)) * 32'd16));
                chk("burst_len", 128'(rq_len[j]), 128'(b - 1));
            end
            w += b; j++;
        end
        chk("burst_count", 128'(rq_addr.size()), 128'(j));
    endtask

    vec_t vecs[10];

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        vec_t rv;
        int   n;
        vecs[0] = '{16'd7,      17'd0,  0, 0,  -1, 1'b0};
        vecs[1] = '{16'd3,      17'd5,  0, 0,  -1, 1'b0};
        vecs[2] = '{16'd0,      17'd40, 0, 0,  -1, 1'b0};
        vecs[3] = '{16'h0100,   17'd33, 3, 30, -1, 1'b0};
        vecs[4] = '{16'd9,      17'd5,  1, 20, 2,  1'b1};
        vecs[5] = '{16'd9,      17'd5,  0, 0,  -1, 1'b0};
        vecs[6] = '{16'hFFFE,   17'd4,  0, 10, -1, 1'b0};
        vecs[7] = '{16'd1,      17'd16, 2, 0,  15, 1'b1};
        vecs[8] = '{16'd20,     17'd17, 0, 50, -1, 1'b0};
        vecs[9] = '{16'd2,      17'd1,  3, 40, -1, 1'b0};

        rst_n = 1'b0; preload_req = 1'b0; preload_base = '0; preload_count = '0;
        stall_cfg = 0; gap_pct = 0; bad_beat = -1; gbeat = 0; cur_count = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(preload_done), 128'(0));
        chk("rst_req_valid", 128'(rd_req_valid), 128'(0));
        chk("rst_req_addr", 128'(rd_req_addr), 128'(0));
        chk("rst_data_ready", 128'(rd_data_ready), 128'(0));
        chk("rst_buf_we", 128'(buf_we), 128'(0));
        chk("rst_err", 128'(err), 128'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) run_xfer(vecs[i]);

        for (int i = 0; i < 6; i++) begin
            rv.base  = 16'($urandom);
            rv.count = 17'($urandom_range(1, 70));
            rv.stall = $urandom_range(0, 3);
            rv.gap   = $urandom_range(0, 60);
            rv.bad   = ($urandom_range(0, 1) == 1) ? $urandom_range(0, int'(rv.count) - 1) : -1;
            rv.exp_err = (rv.bad >= 0);
            run_xfer(rv);
        end

        // Reset in the middle of a burst: transfer abandoned, no done pulse
        chk_done_writes = 1'b0;
        wq_addr.delete(); wq_data.delete(); done_cnt = 0;
        stall_cfg = 0; gap_pct = 0; bad_beat = -1; gbeat = 0;
        preload_base = 16'd5; preload_count = 17'd40; preload_req = 1'b1;
        n = 0;
        while (wq_addr.size() < 3 && n < 200) begin @(posedge clk); #1; n++; end
        chk("pre_reset_progress", 128'(wq_addr.size() >= 3), 128'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", 128'(busy), 128'(0));
        chk("midrst_req_valid", 128'(rd_req_valid), 128'(0));
        chk("midrst_data_ready", 128'(rd_data_ready), 128'(0));
        chk("midrst_buf_we", 128'(buf_we), 128'(0));
        preload_req = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        chk("midrst_no_done", 128'(done_cnt), 128'(0));
        chk("midrst_idle", 128'(busy), 128'(0));
        chk_done_writes = 1'b1;
        run_xfer(vecs[1]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
